// File: rtl/pcm_to_i2s_tx.sv
// -----------------------------------------------------------------------------
// pcm_to_i2s_tx
//
// I2S output stage behind the delay-and-sum beamformer. Takes one stereo pair
// per frame over valid/ready and reduces each channel from IN_BITS to
// NUMBER_OF_BITS. It then serialises the pair MSB-first as a standard I2S frame
// with a one-bit WS delay. A frame is two slots of SLOT_BITS clocks, left first.
//
// Build option:
//   SATURATE_EN  defined   -> clamp the sample to the signed NUMBER_OF_BITS range
//                             (unity gain).
//                undefined -> keep the top NUMBER_OF_BITS bits
//                             (arithmetic shift right by IN_BITS-NUMBER_OF_BITS).
//
// Ports:
//   clk            in   serial bit clock; all logic on posedge
//   rst_n          in   asynchronous active-low reset
//   tx_en          in   transmit enable; sampled at frame boundaries
//   sample_l/_r    in   IN_BITS signed summed samples
//   in_valid       in   sample pair valid
//   in_ready       out  holding register can take a pair this cycle
//   sd_out         out  I2S serial data (registered)
//   ws_out         out  I2S word select, 0 = left, 1 = right (registered)
//   frame_start    out  one-cycle pulse in frame cycle 0
//   underrun       out  one-cycle pulse in cycle 0 of a frame sent without data
//   underrun_cnt   out  saturating count of underrun frames
// -----------------------------------------------------------------------------
module pcm_to_i2s_tx #(
  parameter int NUMBER_OF_BITS = 16,
  parameter int IN_BITS        = 19,
  parameter int SLOT_BITS      = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tx_en,
  input  logic [IN_BITS-1:0] sample_l,
  input  logic [IN_BITS-1:0] sample_r,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               sd_out,
  output logic               ws_out,
  output logic               frame_start,
  output logic               underrun,
  output logic [7:0]         underrun_cnt
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_SLOT  = CNT_W'(SLOT_BITS);
  localparam logic [CNT_W-1:0] CNT_NBITS = CNT_W'(NUMBER_OF_BITS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                    state_q;
  logic [CNT_W-1:0]          bit_cnt_q;
  logic                      hold_valid_q;
  logic [NUMBER_OF_BITS-1:0] hold_l_q;
  logic [NUMBER_OF_BITS-1:0] hold_r_q;
  logic [NUMBER_OF_BITS-1:0] shift_q;   // word currently being shifted out
  logic [NUMBER_OF_BITS-1:0] right_q;   // right word waiting for slot 1
  logic                      sd_q;
  logic                      ws_q;
  logic                      frame_start_q;
  logic                      underrun_q;
  logic [7:0]                underrun_cnt_q;

  // ---------------------------------------------------------------------------
  // Width reduction, applied as the pair enters the holding register
  // ---------------------------------------------------------------------------
  logic [NUMBER_OF_BITS-1:0] red_l;
  logic [NUMBER_OF_BITS-1:0] red_r;

`ifdef SATURATE_EN
  localparam logic signed [IN_BITS-1:0] SAT_MAX = IN_BITS'((2 ** (NUMBER_OF_BITS - 1)) - 1);
  localparam logic signed [IN_BITS-1:0] SAT_MIN = IN_BITS'(-(2 ** (NUMBER_OF_BITS - 1)));

  function automatic logic [NUMBER_OF_BITS-1:0] clamp_word(input logic [IN_BITS-1:0] s);
    if ($signed(s) > SAT_MAX) begin
      clamp_word = {1'b0, {(NUMBER_OF_BITS-1){1'b1}}};
    end else if ($signed(s) < SAT_MIN) begin
      clamp_word = {1'b1, {(NUMBER_OF_BITS-1){1'b0}}};
    end else begin
      clamp_word = s[NUMBER_OF_BITS-1:0];
    end
  endfunction

  assign red_l = clamp_word(sample_l);
  assign red_r = clamp_word(sample_r);
`else
  assign red_l = sample_l[IN_BITS-1 -: NUMBER_OF_BITS];
  assign red_r = sample_r[IN_BITS-1 -: NUMBER_OF_BITS];

  // The discarded LSBs are intentionally dropped by the truncating reduction.
  if (IN_BITS > NUMBER_OF_BITS) begin : g_lsb_sink
    logic unused_lsbs;
    assign unused_lsbs = ^{sample_l[IN_BITS-NUMBER_OF_BITS-1:0],
                           sample_r[IN_BITS-NUMBER_OF_BITS-1:0]};
  end
`endif

  // ---------------------------------------------------------------------------
  // Frame control
  // ---------------------------------------------------------------------------
  logic             frame_last;
  logic             load_now;
  logic             accept;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] pos_nxt;
  logic             ws_nxt;
  logic             data_nxt;

  assign frame_last = (state_q == RUN) && (bit_cnt_q == CNT_LAST);

  // A new frame is loaded either from IDLE once data exists, or at the wrap of
  // a running frame. When tx_en is low at the wrap the block stops instead, so
  // any held pair stays put for the next start and no underrun is counted.
  assign load_now = tx_en && (((state_q == IDLE) && hold_valid_q) || frame_last);
  assign in_ready = !hold_valid_q || load_now;
  assign accept   = in_valid && in_ready;

  // Position of the cycle being entered; outputs are registered, so they are
  // computed one cycle ahead from the next count value.
  assign cnt_nxt  = bit_cnt_q + CNT_ONE;
  assign ws_nxt   = (cnt_nxt >= CNT_SLOT);
  assign pos_nxt  = ws_nxt ? (cnt_nxt - CNT_SLOT) : cnt_nxt;
  assign data_nxt = (pos_nxt != '0) && (pos_nxt <= CNT_NBITS);

  // ---------------------------------------------------------------------------
  // Holding register (one pair deep)
  // ---------------------------------------------------------------------------
  // NOTE: every register here resets asynchronously; the holding data is reset
  // too so a reset mid-frame discards whatever was waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_q <= 1'b0;
      hold_l_q     <= '0;
      hold_r_q     <= '0;
    end else if (accept) begin
      // Covers a simultaneous load and accept: the slot is refilled at once.
      hold_valid_q <= 1'b1;
      hold_l_q     <= red_l;
      hold_r_q     <= red_r;
    end else if (load_now) begin
      hold_valid_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM, shifter and registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every branch
  // reads the pre-edge values of the registers regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      right_q        <= '0;
      sd_q           <= 1'b0;
      ws_q           <= 1'b0;
      frame_start_q  <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      // Pulses default low and are raised only in the cycle-0 load branch.
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;

      if (load_now) begin
        // Entering frame cycle 0: WS low, no data bit yet (one-bit WS delay).
        state_q       <= RUN;
        bit_cnt_q     <= '0;
        ws_q          <= 1'b0;
        sd_q          <= 1'b0;
        frame_start_q <= 1'b1;
        if (hold_valid_q) begin
          shift_q <= hold_l_q;
          right_q <= hold_r_q;
        end else begin
          // Only reachable from RUN: a running frame wrapped with nothing held.
          shift_q    <= '0;
          right_q    <= '0;
          underrun_q <= 1'b1;
          if (underrun_cnt_q != 8'hFF) begin
            underrun_cnt_q <= underrun_cnt_q + 8'd1;
          end
        end
      end else if ((state_q == RUN) && !frame_last) begin
        bit_cnt_q <= cnt_nxt;
        ws_q      <= ws_nxt;
        if (cnt_nxt == CNT_SLOT) begin
          // Slot 1 cycle 0: swap in the right word; its MSB follows next clock.
          shift_q <= right_q;
          sd_q    <= 1'b0;
        end else if (data_nxt) begin
          sd_q    <= shift_q[NUMBER_OF_BITS-1];
          shift_q <= {shift_q[NUMBER_OF_BITS-2:0], 1'b0};
        end else begin
          sd_q <= 1'b0;
        end
      end else begin
        // Idle, or a finished frame with tx_en low.
        state_q   <= IDLE;
        bit_cnt_q <= '0;
        ws_q      <= 1'b0;
        sd_q      <= 1'b0;
      end
    end
  end

  assign sd_out       = sd_q;
  assign ws_out       = ws_q;
  assign frame_start  = frame_start_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_pcm_to_i2s_tx.sv
// -----------------------------------------------------------------------------
// tb_pcm_to_i2s_tx
//
// Self-checking bench for pcm_to_i2s_tx (N=16, IN=19, SLOT=32). A frame-level
// reference model (queue of pending words, frame cycle counter) predicts
// in_ready and all serial outputs every clock. Directed sequences exercise
// the spec scenarios, followed by a randomized phase. Build with or without
// SATURATE_EN to match the RTL build.
// -----------------------------------------------------------------------------
module tb_pcm_to_i2s_tx;

  localparam int N     = 16;
  localparam int IN    = 19;
  localparam int SLOT  = 32;
  localparam int FRAME = 2 * SLOT;

`ifdef SATURATE_EN
  localparam logic [N-1:0] T2_L = 16'h0ABC;
  localparam logic [N-1:0] T2_R = 16'hFF00;
  localparam logic [N-1:0] T3_L = 16'h7FFF;
  localparam logic [N-1:0] T3_R = 16'h8000;
`else
  localparam logic [N-1:0] T2_L = 16'h0157;
  localparam logic [N-1:0] T2_R = 16'hFFE0;
  localparam logic [N-1:0] T3_L = 16'h2000;
  localparam logic [N-1:0] T3_R = 16'hC780;
`endif

  logic          clk;
  logic          rst_n;
  logic          tx_en;
  logic [IN-1:0] sample_l;
  logic [IN-1:0] sample_r;
  logic          in_valid;
  logic          in_ready;
  logic          sd_out;
  logic          ws_out;
  logic          frame_start;
  logic          underrun;
  logic [7:0]    underrun_cnt;

  pcm_to_i2s_tx #(
    .NUMBER_OF_BITS(N),
    .IN_BITS       (IN),
    .SLOT_BITS     (SLOT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_en       (tx_en),
    .sample_l    (sample_l),
    .sample_r    (sample_r),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sd_out      (sd_out),
    .ws_out      (ws_out),
    .frame_start (frame_start),
    .underrun    (underrun),
    .underrun_cnt(underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [2*N-1:0] m_hold[$];   // accepted pairs not yet transmitted
  bit             m_run;
  int             m_c;         // frame cycle currently on the outputs
  logic [N-1:0]   m_l, m_r;    // words of the current frame
  bit             m_und;       // current frame is an underrun frame
  int             m_cnt;

  // Decoded serial stream
  logic [N-1:0] obs_l, obs_r, dec_l, dec_r;
  int           ws_hi, dec_ws;
  logic         und_seen, dec_und;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, required 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hold.delete();
    m_run = 0;
    m_c   = 0;
    m_l   = '0;
    m_r   = '0;
    m_und = 0;
    m_cnt = 0;
  endtask

  // Spec rule: clamp to signed 16-bit, or arithmetic shift right by IN-N.
  function automatic logic [N-1:0] reduce(input logic [IN-1:0] s);
    int v;
    v = int'($signed(s));
`ifdef SATURATE_EN
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
`else
    v = v >>> (IN - N);
`endif
    return v[N-1:0];
  endfunction

  function automatic logic [IN-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 19'h07FFF;
      1:       return 19'h08000;
      2:       return 19'h78000;
      3:       return 19'h77FFF;
      4:       return 19'h3FFFF;
      5:       return 19'h40000;
      default: return 19'($urandom);
    endcase
  endfunction

  // {ws, sd, frame_start, underrun, underrun_cnt} for the current model cycle
  function automatic logic [11:0] expected_outs();
    logic ws, sd, fs, und;
    int k;
    logic [N-1:0] w;
    ws = 0; sd = 0; fs = 0; und = 0;
    if (m_run) begin
      ws = (m_c >= SLOT);
      k  = m_c % SLOT;
      w  = ws ? m_r : m_l;
      if (k >= 1 && k <= N) sd = w[N-k];
      fs  = (m_c == 0);
      und = fs && m_und;
    end
    return {ws, sd, fs, und, 8'(m_cnt)};
  endfunction

  // One clock: called at a negedge with inputs already driven.
  task automatic step();
    logic ld, rdy, acc;
    int k;
    #1;
    ld  = tx_en && ((!m_run && m_hold.size() != 0) || (m_run && m_c == FRAME - 1));
    rdy = (m_hold.size() == 0) || ld;
    check("in_ready", 32'(in_ready), 32'(rdy));
    acc = in_valid && rdy;
    @(posedge clk);
    if (ld) begin
      if (m_hold.size() != 0) begin
        {m_l, m_r} = m_hold.pop_front();
        m_und = 0;
      end else begin
        m_l = '0;
        m_r = '0;
        m_und = 1;
        if (m_cnt < 255) m_cnt++;
      end
      m_run = 1;
      m_c   = 0;
    end else if (m_run) begin
      if (m_c == FRAME - 1) begin
        m_run = 0;
        m_c   = 0;
      end else begin
        m_c++;
      end
    end
    if (acc) m_hold.push_back({reduce(sample_l), reduce(sample_r)});
    @(negedge clk);
    check("outputs", 32'({ws_out, sd_out, frame_start, underrun, underrun_cnt}),
          32'(expected_outs()));
    if (m_run) begin
      k = m_c % SLOT;
      if (m_c == 0) begin
        obs_l    = '0;
        obs_r    = '0;
        ws_hi    = 0;
        und_seen = underrun;
      end
      ws_hi += int'(ws_out);
      if (k >= 1 && k <= N) begin
        if (m_c < SLOT) obs_l = {obs_l[N-2:0], sd_out};
        else            obs_r = {obs_r[N-2:0], sd_out};
      end
      if (m_c == FRAME - 1) begin
        dec_l   = obs_l;
        dec_r   = obs_r;
        dec_ws  = ws_hi;
        dec_und = und_seen;
      end
    end
  endtask

  // Step at least once, until the model is running at frame cycle target.
  task automatic run_to(input int target);
    int i;
    i = 0;
    do begin
      step();
      i++;
    end while (!(m_run && m_c == target) && i < 4000);
    if (!(m_run && m_c == target)) check("run_to_timeout", 32'(m_run), 32'd1);
  endtask

  logic [2*N-1:0] exp_a, exp_b;
  int             fs_cnt;

  initial begin
    rst_n    = 1'b0;
    tx_en    = 1'b0;
    in_valid = 1'b0;
    sample_l = '0;
    sample_r = '0;
    obs_l = '0; obs_r = '0; dec_l = '0; dec_r = '0;
    ws_hi = 0; dec_ws = 0; und_seen = 0; dec_und = 0;
    model_reset();

    // Reset values
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sd", 32'(sd_out), 32'd0);
    check("rst_ws", 32'(ws_out), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_underrun_cnt", 32'(underrun_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: enabled but no data -> lines stay quiet
    tx_en = 1'b1;
    repeat (100) step();
    check("t1_idle_lines", 32'({ws_out, sd_out}), 32'd0);

    // 2: first pair, second pair queued mid-frame
    sample_l = 19'h00ABC; sample_r = 19'h7FF00; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    run_to(5);
    sample_l = 19'h10000; sample_r = 19'h63C00; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    run_to(FRAME - 1);
    check("t2_left", 32'(dec_l), 32'(T2_L));
    check("t2_right", 32'(dec_r), 32'(T2_R));
    check("t2_ws_high_cycles", 32'(dec_ws), 32'(SLOT));

    // 3: out-of-range pair
    run_to(FRAME - 1);
    check("t3_left", 32'(dec_l), 32'(T3_L));
    check("t3_right", 32'(dec_r), 32'(T3_R));

    // 4: starvation
    run_to(0);
    check("t4_underrun_pulse", 32'(underrun), 32'd1);
    check("t4_underrun_cnt", 32'(underrun_cnt), 32'd1);
    run_to(FRAME - 1);
    check("t4_zero_left", 32'(dec_l), 32'd0);
    check("t4_zero_right", 32'(dec_r), 32'd0);
    repeat (300) run_to(FRAME - 1);
    check("t4_cnt_saturated", 32'(underrun_cnt), 32'd255);

    // 5: pair arriving exactly in the load cycle while the hold is full
    run_to(3);
    sample_l = pick(); sample_r = pick(); in_valid = 1'b1;
    exp_a = {reduce(sample_l), reduce(sample_r)};
    step();
    in_valid = 1'b0;
    run_to(FRAME - 1);
    sample_l = pick(); sample_r = pick(); in_valid = 1'b1;
    exp_b = {reduce(sample_l), reduce(sample_r)};
    #1;
    check("t5_in_ready_at_load", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    run_to(FRAME - 1);
    check("t5_first_pair", 32'({dec_l, dec_r}), 32'(exp_a));
    check("t5_first_no_underrun", 32'(dec_und), 32'd0);
    run_to(FRAME - 1);
    check("t5_second_pair", 32'({dec_l, dec_r}), 32'(exp_b));
    check("t5_second_no_underrun", 32'(dec_und), 32'd0);

    // Randomized traffic with occasional tx_en drops
    repeat (2500) begin
      tx_en    = ($urandom_range(0, 7) != 0);
      in_valid = ($urandom_range(0, 2) == 0);
      sample_l = pick();
      sample_r = pick();
      step();
    end
    in_valid = 1'b0;

    // 6: tx_en dropped mid-frame, then reset mid-frame
    tx_en = 1'b1;
    sample_l = pick(); sample_r = pick(); in_valid = 1'b1;
    run_to(10);
    in_valid = 1'b0;
    tx_en = 1'b0;
    run_to(FRAME - 1);
    step();
    fs_cnt = 0;
    repeat (20) begin
      step();
      fs_cnt += int'(frame_start);
    end
    check("t6_no_frames_when_disabled", 32'(fs_cnt), 32'd0);
    check("t6_idle_lines", 32'({ws_out, sd_out}), 32'd0);

    tx_en = 1'b1;
    sample_l = pick(); sample_r = pick(); in_valid = 1'b1;
    run_to(40);
    in_valid = 1'b0;
    check("t6_ws_before_reset", 32'(ws_out), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_ws", 32'(ws_out), 32'd0);
    check("t6_rst_sd", 32'(sd_out), 32'd0);
    check("t6_rst_in_ready", 32'(in_ready), 32'd1);
    check("t6_rst_frame_start", 32'(frame_start), 32'd0);
    check("t6_rst_underrun_cnt", 32'(underrun_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Recovery after reset
    sample_l = pick(); sample_r = pick(); in_valid = 1'b1;
    exp_a = {reduce(sample_l), reduce(sample_r)};
    step();
    in_valid = 1'b0;
    run_to(FRAME - 1);
    check("t6_recover_pair", 32'({dec_l, dec_r}), 32'(exp_a));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
